div_sequencer: RTL and testbench
================================

DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter N, default 4, giving the operand and result width in bits.
REQ-002 SHALL have clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have startIn, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 SHALL have aIn, input, N bits: unsigned dividend; captured when a start is accepted.
REQ-006 SHALL have bIn, input, N bits: unsigned divisor; captured when a start is accepted.
REQ-007 SHALL have busyOut, output, 1 bit: high while in RUN or DONE.
REQ-008 SHALL have doneOut, output, 1 bit: one-cycle pulse when results are valid.
REQ-009 SHALL have cOut, output, N bits: quotient register.
REQ-010 SHALL have mod, output, N bits: remainder register.
REQ-011 SHALL have divZeroOut, output, 1 bit: flags that the last completed operation had a zero divisor.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN and DONE, held in registers.
REQ-013 SHALL accept a start only in IDLE with startIn=1; at that edge it latches aIn into the quotient shift register, bIn into the divisor register and N-1 into the step counter, clears the partial remainder, and enters RUN.
REQ-014 SHALL, on accepting a start with bIn=0, go to DONE instead of RUN, load cOut=all ones, load mod=aIn and set divZeroOut=1.
REQ-015 SHALL, in each RUN cycle, perform one restoring step: shift {remainder,quotient} left by 1, trial-subtract the divisor from the (N+1)-bit remainder, keep the difference and set quotient LSB=1 if it is non-negative, else restore and set LSB=0.
REQ-016 SHALL hold the partial remainder in N+1 bits, so that no step overflows for any divisor up to 2^N-1.
REQ-017 SHALL decrement the counter every RUN cycle and leave RUN for DONE on the edge where the counter is 0, giving exactly N RUN cycles.
REQ-018 SHALL, on the RUN->DONE edge, load cOut with the quotient, load mod with the remainder (low N bits) and clear divZeroOut.
REQ-019 SHALL assert doneOut for exactly the one cycle spent in DONE, then return to IDLE on the next edge.
REQ-020 SHALL give a latency of N+1 edges from the accept edge to the edge that enters DONE for a non-zero divisor, and 1 edge for a zero divisor.
REQ-021 SHALL drive busyOut combinationally from the state: 0 in IDLE, 1 in RUN and DONE.
REQ-022 SHALL ignore startIn in RUN and DONE, and SHALL ignore operand changes after the accept edge.
REQ-023 SHALL hold cOut, mod and divZeroOut stable from one completion to the next, including through IDLE and RUN.
REQ-024 SHALL produce cOut=floor(a/b) and mod=a mod b for every b≠0, for all 2^(2N) operand pairs.
REQ-025 SHALL accept back-to-back operations, with startIn high in the IDLE cycle right after DONE accepted.

Reset
REQ-026 SHALL, with rst=0 at a rising edge, force state=IDLE, counter=0 and all internal registers to 0.
REQ-027 SHALL, on that reset edge, drive cOut=0, mod=0, divZeroOut=0, busyOut=0 and doneOut=0.
REQ-028 SHALL abort any operation in progress on reset with no doneOut pulse, and SHALL take rst priority over startIn on the same edge.
REQ-029 SHALL accept a start on the first edge after rst returns to 1.

Verification
REQ-030 SHALL cover (N=4) a=13, b=4, start pulse -> busy for 5 cycles, doneOut 1 cycle, 5 edges after accept, with cOut=3, mod=1, divZeroOut=0.
REQ-031 SHALL cover a=3, b=9 -> cOut=0, mod=3; and a=15, b=1 -> cOut=15, mod=0.
REQ-032 SHALL cover a=7, b=0 -> DONE 1 edge after accept, with cOut=15, mod=7, divZeroOut=1; the next op a=8, b=2 -> cOut=4, mod=0, divZeroOut=0.
REQ-033 SHALL cover start a=9, b=2, then on cycle 2 startIn=1 with a=1, b=1 and aIn changed -> the second request is ignored, giving cOut=4, mod=1.
REQ-034 SHALL cover rst=0 on cycle 3 of RUN -> next cycle all outputs 0, no doneOut; a start right after reset completes correctly.
REQ-035 SHALL cover an exhaustive back-to-back sweep of all 256 (a,b) pairs -> every result matches a/b and a%b, with the zero-divisor rule applied.

Source files
------------

// File: rtl/div_sequencer.sv
// div_sequencer: unsigned restoring divider with a small start/run/done
// sequencer. One quotient bit is resolved per RUN cycle, so an operation
// takes N RUN cycles followed by a single DONE cycle. A zero divisor skips
// RUN and goes straight to DONE with the saturated result.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-low reset
//   startIn    : request a division (only looked at in IDLE)
//   aIn, bIn   : unsigned dividend / divisor, captured on the accept edge
//   busyOut    : high in RUN and DONE
//   doneOut    : one-cycle pulse while results are fresh
//   cOut, mod  : quotient / remainder, held until the next completion
//   divZeroOut : last completed operation had a zero divisor
module div_sequencer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         startIn,
  input  logic [N-1:0] aIn,
  input  logic [N-1:0] bIn,
  output logic         busyOut,
  output logic         doneOut,
  output logic [N-1:0] cOut,
  output logic [N-1:0] mod,
  output logic         divZeroOut
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [N-1:0]  quo_q;
  logic [N-1:0]  div_q;
  logic [N:0]    rem_q;
  logic [CW-1:0] cnt_q;
  logic          done_q;
  logic [N-1:0]  c_q;
  logic [N-1:0]  mod_q;
  logic          dz_q;

  logic [N:0]    rem_sh;
  logic [N+1:0]  diff;
  logic [N:0]    quo_sh;
  logic [N-1:0]  quo_d;
  logic [N:0]    rem_d;

  // One restoring step. The remainder is always below the divisor, so the
  // shifted value fits in N+1 bits; one extra bit on the difference gives
  // the sign of the trial subtraction.
  always_comb begin
    rem_sh = {rem_q[N-1:0], quo_q[N-1]};
    diff   = {1'b0, rem_sh} - {2'b00, div_q};
    quo_sh = {quo_q, ~diff[N+1]};
    quo_d  = quo_sh[N-1:0];
    rem_d  = diff[N+1] ? rem_sh : diff[N:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      quo_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      c_q     <= '0;
      mod_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (startIn) begin
            quo_q <= aIn;
            div_q <= bIn;
            rem_q <= '0;
            cnt_q <= CW'(N - 1);
            if (bIn == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              c_q     <= '1;
              mod_q   <= aIn;
              dz_q    <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q - CW'(1);
          // Results are taken from this cycle's step, not the registers.
          if (cnt_q == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            c_q     <= quo_d;
            mod_q   <= rem_d[N-1:0];
            dz_q    <= 1'b0;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busyOut    = (state_q != IDLE);
  assign doneOut    = done_q;
  assign cOut       = c_q;
  assign mod        = mod_q;
  assign divZeroOut = dz_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer (N=4): the driver pushes the expected
// result and busy-cycle latency for every accepted request; a monitor pops
// and compares each time doneOut is seen.
module tb_div_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       startIn;
  logic [3:0] aIn;
  logic [3:0] bIn;
  logic       busyOut;
  logic       doneOut;
  logic [3:0] cOut;
  logic [3:0] mod;
  logic       divZeroOut;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] c;
    logic [3:0] m;
    logic       dz;
    int         lat;
  } exp_t;

  exp_t sb[$];

  div_sequencer #(.N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .startIn   (startIn),
    .aIn       (aIn),
    .bIn       (bIn),
    .busyOut   (busyOut),
    .doneOut   (doneOut),
    .cOut      (cOut),
    .mod       (mod),
    .divZeroOut(divZeroOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: busy-cycle counter gives the latency seen at the done pulse.
  int bcnt = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (busyOut === 1'b1) bcnt++;
    else bcnt = 0;
    if (doneOut === 1'b1) begin
      chk("done_single_cycle", prev_done, 0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual cOut=%0d mod=%0d required no pulse", cOut, mod);
      end else begin
        e = sb.pop_front();
        chk("quotient", cOut, e.c);
        chk("remainder", mod, e.m);
        chk("divzero", divZeroOut, e.dz);
        chk("latency", bcnt, e.lat);
      end
    end
    prev_done = doneOut;
  end

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    if (b == 4'd0) begin
      e.c = 4'hF; e.m = a; e.dz = 1'b1; e.lat = 1;
    end else begin
      e.c = a / b; e.m = a % b; e.dz = 1'b0; e.lat = 5;
    end
    return e;
  endfunction

  // Entered and left at a negative edge.
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input exp_t e, input bit push);
    int g = 0;
    while (busyOut && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (busyOut) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout busy still high, required idle");
    end
    startIn = 1'b1;
    aIn     = a;
    bIn     = b;
    if (push) sb.push_back(e);
    @(negedge clk);
    startIn = 1'b0;
    aIn     = ~a;
    bIn     = ~b;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busyOut && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("idle_reached", busyOut, 0);
  endtask

  function automatic exp_t mk(input logic [3:0] c, input logic [3:0] m, input logic dz, input int lat);
    exp_t e;
    e.c = c; e.m = m; e.dz = dz; e.lat = lat;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; startIn = 1'b0; aIn = '0; bIn = '0;
    repeat (3) @(negedge clk);
    chk("rst_cOut", cOut, 0);
    chk("rst_mod", mod, 0);
    chk("rst_dz", divZeroOut, 0);
    chk("rst_busy", busyOut, 0);
    chk("rst_done", doneOut, 0);
    rst = 1'b1;

    issue(4'd13, 4'd4, mk(4'd3, 4'd1, 1'b0, 5), 1);
    issue(4'd3, 4'd9, mk(4'd0, 4'd3, 1'b0, 5), 1);
    issue(4'd15, 4'd1, mk(4'd15, 4'd0, 1'b0, 5), 1);
    issue(4'd7, 4'd0, mk(4'd15, 4'd7, 1'b1, 1), 1);
    issue(4'd8, 4'd2, mk(4'd4, 4'd0, 1'b0, 5), 1);

    // Requests during RUN must be ignored.
    issue(4'd9, 4'd2, mk(4'd4, 4'd1, 1'b0, 5), 1);
    startIn = 1'b1; aIn = 4'd1; bIn = 4'd1;
    repeat (2) @(negedge clk);
    startIn = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("hold_idle_cOut", cOut, 4);
    chk("hold_idle_mod", mod, 1);

    // Reset in the third RUN cycle aborts with no done pulse.
    issue(4'd13, 4'd4, mk(4'd0, 4'd0, 1'b0, 0), 0);
    chk("hold_run_cOut", cOut, 4);
    chk("hold_run_busy", busyOut, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_cOut", cOut, 0);
    chk("abort_mod", mod, 0);
    chk("abort_dz", divZeroOut, 0);
    chk("abort_busy", busyOut, 0);
    chk("abort_done", doneOut, 0);
    startIn = 1'b1; aIn = 4'd5; bIn = 4'd1;
    @(negedge clk);
    chk("rst_over_start_busy", busyOut, 0);
    startIn = 1'b0;
    rst = 1'b1;
    issue(4'd6, 4'd4, mk(4'd1, 4'd2, 1'b0, 5), 1);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        issue(4'(a), 4'(b), model(4'(a), 4'(b)), 1);

    wait_idle();
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
